// File: rtl/sys_cmd_pkg.sv
// Shared opcodes, FSM states and response constants for sys_cmd_ctrl.
// Consumed by sys_cmd_ctrl and sys_cmd_tx_ser.
package sys_cmd_pkg;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    localparam logic [1:0] RSP_RD_BYTES  = 2'd1;
    localparam logic [1:0] RSP_ALU_BYTES = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_SEND
    } state_e;

    // States that sit mid-frame waiting for the next RX byte.
    function automatic logic is_collect(input state_e s);
        return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                         ST_OP_A, ST_OP_B, ST_ALU_FUN};
    endfunction

endpackage

// File: rtl/sys_cmd_tx_ser.sv
// Two-entry response holder; pushes bytes LSB-first into the TX FIFO.
// A push is issued only with FIFO_FULL low, one byte every other cycle.
module sys_cmd_tx_ser
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [1:0]            nbytes,
    input  logic [DATA_WIDTH-1:0] byte0,
    input  logic [DATA_WIDTH-1:0] byte1,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_inc
);

    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] hi;

    assign busy = (cnt != 2'd0);

    // The idle cycle between pushes lets the full flag reflect the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 2'd0;
            hi      <= '0;
            wr_data <= '0;
            wr_inc  <= 1'b0;
        end else begin
            wr_inc <= 1'b0;
            if (load) begin
                cnt     <= nbytes;
                hi      <= byte1;
                wr_data <= byte0;
            end else if (wr_inc) begin
                cnt <= cnt - 1'b1;
                if (cnt == RSP_ALU_BYTES) wr_data <= hi;
            end else if (busy && !fifo_full) begin
                wr_inc <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: RX frames -> RF access / ALU ops -> TX bytes.
// Optional inter-byte timeout enabled by defining SYS_CMD_TIMEOUT_EN.
module sys_cmd_ctrl
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic                    FIFO_FULL,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    WR_INC,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLKG_EN,
    output logic                    CLKDIV_EN,
    output logic                    FRAME_ERR
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  byte_drop;
    logic                  to_hit;
    logic                  tx_load;
    logic                  tx_busy;
    logic [1:0]            tx_n;
    logic [DATA_WIDTH-1:0] tx_b0;
    logic [DATA_WIDTH-1:0] tx_b1;

    assign byte_drop = RX_D_VLD && !is_collect(state) && (state != ST_IDLE);

    always_comb begin
        tx_load = 1'b0;
        tx_n    = RSP_RD_BYTES;
        tx_b0   = RF_RdData;
        tx_b1   = '0;
        if (state == ST_RD_WAIT && RF_RdData_VLD) begin
            tx_load = 1'b1;
        end else if (state == ST_ALU_WAIT && ALU_OUT_VLD) begin
            tx_load = 1'b1;
            tx_n    = RSP_ALU_BYTES;
            tx_b0   = ALU_OUT[DATA_WIDTH-1:0];
            tx_b1   = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

`ifdef SYS_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    assign to_hit = is_collect(state) && !RX_D_VLD
                 && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (is_collect(state) && !RX_D_VLD && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    // No timeout: a partial frame waits indefinitely for its next byte.
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLKG_EN    <= 1'b0;
            CLKDIV_EN  <= 1'b1;
            FRAME_ERR  <= 1'b0;
        end else begin
            RF_WrEn   <= 1'b0;
            RF_RdEn   <= 1'b0;
            ALU_EN    <= 1'b0;
            CLKDIV_EN <= 1'b1;
            FRAME_ERR <= byte_drop;
            if (to_hit) begin
                state     <= ST_IDLE;
                FRAME_ERR <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (RX_D_VLD) begin
                            unique case (1'b1)
                                RX_P_DATA == DATA_WIDTH'(OPC_RF_WR):
                                    state <= ST_WR_ADDR;
                                RX_P_DATA == DATA_WIDTH'(OPC_RF_RD):
                                    state <= ST_RD_ADDR;
                                RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP):
                                    state <= ST_OP_A;
                                RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP):
                                    state <= ST_ALU_FUN;
                                default:
                                    FRAME_ERR <= 1'b1;
                            endcase
                        end
                    end
                    ST_WR_ADDR: begin
                        if (RX_D_VLD) begin
                            addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state  <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        if (RX_D_VLD) begin
                            RF_WrEn    <= 1'b1;
                            RF_Address <= addr_q;
                            RF_WrData  <= RX_P_DATA;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (RX_D_VLD) begin
                            RF_RdEn    <= 1'b1;
                            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state      <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (RF_RdData_VLD) state <= ST_TX_SEND;
                    end
                    ST_OP_A: begin
                        if (RX_D_VLD) begin
                            RF_WrEn    <= 1'b1;
                            RF_Address <= ADDR_WIDTH'(OPA_ADDR);
                            RF_WrData  <= RX_P_DATA;
                            state      <= ST_OP_B;
                        end
                    end
                    ST_OP_B: begin
                        if (RX_D_VLD) begin
                            RF_WrEn    <= 1'b1;
                            RF_Address <= ADDR_WIDTH'(OPB_ADDR);
                            RF_WrData  <= RX_P_DATA;
                            state      <= ST_ALU_FUN;
                        end
                    end
                    ST_ALU_FUN: begin
                        if (RX_D_VLD) begin
                            ALU_EN  <= 1'b1;
                            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                            CLKG_EN <= 1'b1;
                            state   <= ST_ALU_WAIT;
                        end
                    end
                    ST_ALU_WAIT: begin
                        if (ALU_OUT_VLD) begin
                            CLKG_EN <= 1'b0;
                            state   <= ST_TX_SEND;
                        end
                    end
                    ST_TX_SEND: begin
                        if (!tx_busy) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    sys_cmd_tx_ser #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tx_ser (
        .clk      (CLK),
        .rst      (RST),
        .load     (tx_load),
        .nbytes   (tx_n),
        .byte0    (tx_b0),
        .byte1    (tx_b1),
        .fifo_full(FIFO_FULL),
        .busy     (tx_busy),
        .wr_data  (WR_DATA),
        .wr_inc   (WR_INC)
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: frame-level reference model with RF/ALU/FIFO
// responders; directed cases followed by random frames.
module tb_sys_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 64;

    localparam logic [7:0] OP_WR  = 8'hAA;
    localparam logic [7:0] OP_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU = 8'hCC;
    localparam logic [7:0] OP_NOP = 8'hDD;

    logic            CLK = 1'b0;
    logic            RST;
    logic [DW-1:0]   RX_P_DATA;
    logic            RX_D_VLD;
    logic            FIFO_FULL;
    logic [DW-1:0]   WR_DATA;
    logic            WR_INC;
    logic            RF_WrEn;
    logic            RF_RdEn;
    logic [AW-1:0]   RF_Address;
    logic [DW-1:0]   RF_WrData;
    logic [DW-1:0]   RF_RdData;
    logic            RF_RdData_VLD;
    logic            ALU_EN;
    logic [FW-1:0]   ALU_FUN;
    logic [2*DW-1:0] ALU_OUT;
    logic            ALU_OUT_VLD;
    logic            CLKG_EN;
    logic            CLKDIV_EN;
    logic            FRAME_ERR;

    always #5 CLK = ~CLK;

    sys_cmd_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .FUN_WIDTH     (FW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .FIFO_FULL    (FIFO_FULL),
        .WR_DATA      (WR_DATA),
        .WR_INC       (WR_INC),
        .RF_WrEn      (RF_WrEn),
        .RF_RdEn      (RF_RdEn),
        .RF_Address   (RF_Address),
        .RF_WrData    (RF_WrData),
        .RF_RdData    (RF_RdData),
        .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .ALU_OUT      (ALU_OUT),
        .ALU_OUT_VLD  (ALU_OUT_VLD),
        .CLKG_EN      (CLKG_EN),
        .CLKDIV_EN    (CLKDIV_EN),
        .FRAME_ERR    (FRAME_ERR)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] rf  [16];
    logic [7:0] mem [16];
    int wr_q[$], rd_q[$], alu_q[$], tx_q[$];
    int exp_wr[$], exp_rd[$], exp_alu[$], exp_tx[$];
    int err_obs = 0;
    int exp_err = 0;
    bit bp_force = 1'b0;
    int gap_max = 2;
    logic [7:0] fq[$];

    logic [30:0] outs;
    assign outs = {WR_DATA, WR_INC, RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
                   ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN, FRAME_ERR};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_f(input logic [3:0] f,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {b, a};
            default: return {a ^ b, a & b};
        endcase
    endfunction

    // Observed activity, sampled away from the active edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (RF_WrEn) begin
                wr_q.push_back(int'({RF_Address, RF_WrData}));
                rf[RF_Address] = RF_WrData;
            end
            if (RF_RdEn) rd_q.push_back(int'(RF_Address));
            if (ALU_EN) begin
                alu_q.push_back(int'(ALU_FUN));
                check("clkg_on", 32'(CLKG_EN), 32'd1);
            end
            if (WR_INC) begin
                tx_q.push_back(int'(WR_DATA));
                check("push_while_full", 32'(FIFO_FULL), 32'd0);
            end
            if (FRAME_ERR) err_obs++;
        end
    end

    initial begin
        FIFO_FULL = 1'b0;
        forever begin
            @(negedge CLK);
            if (!WR_INC) FIFO_FULL = bp_force || ($urandom_range(0, 3) == 0);
        end
    end

    initial begin : rd_resp
        logic [AW-1:0] ra;
        RF_RdData     = '0;
        RF_RdData_VLD = 1'b0;
        forever begin
            @(negedge CLK);
            if (RF_RdEn && !RST) begin
                ra = RF_Address;
                repeat (2) @(negedge CLK);
                RF_RdData     = rf[ra];
                RF_RdData_VLD = 1'b1;
                @(negedge CLK);
                RF_RdData_VLD = 1'b0;
            end
        end
    end

    initial begin
        ALU_OUT     = '0;
        ALU_OUT_VLD = 1'b0;
        forever begin
            @(negedge CLK);
            if (ALU_EN && !RST) begin
                repeat ($urandom_range(1, 4)) @(negedge CLK);
                ALU_OUT     = alu_f(ALU_FUN, rf[0], rf[1]);
                ALU_OUT_VLD = 1'b1;
                @(negedge CLK);
                ALU_OUT_VLD = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Frame-level model: what one frame must produce, trailing bytes dropped.
    task automatic model_frame;
        int used;
        logic [15:0] r;
        used = 1;
        case (fq[0])
            OP_WR: begin
                mem[fq[1][3:0]] = fq[2];
                exp_wr.push_back(int'(fq[1][3:0]) * 256 + int'(fq[2]));
                used = 3;
            end
            OP_RD: begin
                exp_rd.push_back(int'(fq[1][3:0]));
                exp_tx.push_back(int'(mem[fq[1][3:0]]));
                used = 2;
            end
            OP_ALU: begin
                mem[0] = fq[1];
                mem[1] = fq[2];
                exp_wr.push_back(int'(fq[1]));
                exp_wr.push_back(256 + int'(fq[2]));
                r = alu_f(fq[3][3:0], fq[1], fq[2]);
                exp_alu.push_back(int'(fq[3][3:0]));
                exp_tx.push_back(int'(r[7:0]));
                exp_tx.push_back(int'(r[15:8]));
                used = 4;
            end
            OP_NOP: begin
                r = alu_f(fq[1][3:0], mem[0], mem[1]);
                exp_alu.push_back(int'(fq[1][3:0]));
                exp_tx.push_back(int'(r[7:0]));
                exp_tx.push_back(int'(r[15:8]));
                used = 2;
            end
            default: exp_err++;
        endcase
        exp_err += fq.size() - used;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge CLK);
    endtask

    task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check(tag, 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic finish_frame;
        int n = 0;
        while (n < 300 && (wr_q.size() < exp_wr.size()
                || rd_q.size() < exp_rd.size()
                || alu_q.size() < exp_alu.size()
                || tx_q.size() < exp_tx.size())) begin
            @(negedge CLK);
            n++;
        end
        check("frame_budget", 32'(n < 300), 32'd1);
        repeat (8) @(negedge CLK);
        cmp_q("rf_wr", wr_q, exp_wr);
        cmp_q("rf_rd", rd_q, exp_rd);
        cmp_q("alu_fun", alu_q, exp_alu);
        cmp_q("tx_byte", tx_q, exp_tx);
        check("frame_err", 32'(err_obs), 32'(exp_err));
        check("clkg_off", 32'(CLKG_EN), 32'd0);
        wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete();
        exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
        err_obs = 0;
        exp_err = 0;
    endtask

    task automatic run_frame;
        model_frame();
        foreach (fq[i]) send_byte(fq[i]);
        finish_frame();
    endtask

    task automatic set3(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int n);
        fq.delete();
        fq.push_back(a);
        if (n > 1) fq.push_back(b);
        if (n > 2) fq.push_back(c);
    endtask

    initial begin
        logic [7:0] b;
        RX_P_DATA = '0;
        RX_D_VLD  = 1'b0;
        RST       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf[i]  = '0;
            mem[i] = '0;
        end
        #2 RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_outputs", 32'(outs), 32'h2);
        RST = 1'b0;
        @(negedge CLK);

        set3(OP_WR, 8'h05, 8'h3C, 3);
        run_frame();
        set3(OP_RD, 8'h05, 8'h00, 2);
        run_frame();
        set3(OP_ALU, 8'h0A, 8'h14, 3);
        fq.push_back(8'h00);
        run_frame();

        // Back-pressure: full flag held while the 0xBEEF result is pending.
        bp_force = 1'b1;
        set3(OP_ALU, 8'hEF, 8'hBE, 3);
        fq.push_back(8'h03);
        model_frame();
        foreach (fq[i]) send_byte(fq[i]);
        repeat (20) @(negedge CLK);
        check("bp_no_push", 32'(tx_q.size()), 32'd0);
        bp_force = 1'b0;
        finish_frame();

        set3(8'h55, 8'h00, 8'h00, 1);
        run_frame();

        gap_max = 0;
        set3(OP_RD, 8'h05, 8'h77, 3);
        run_frame();
        gap_max = 2;

        set3(OP_NOP, 8'h00, 8'h00, 2);
        run_frame();

        send_byte(OP_WR);
        send_byte(8'h05);
        RST = 1'b1;
        @(negedge CLK);
        check("midframe_reset", 32'(outs), 32'h2);
        check("midframe_no_wr", 32'(wr_q.size()), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        set3(OP_RD, 8'h05, 8'h00, 2);
        run_frame();

`ifdef SYS_CMD_TIMEOUT_EN
        send_byte(OP_WR);
        send_byte(8'h05);
        exp_err = 1;
        repeat (TO + 10) @(negedge CLK);
        finish_frame();
        set3(OP_WR, 8'h02, 8'h7F, 3);
        run_frame();
`endif

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: set3(OP_WR, 8'($urandom), 8'($urandom), 3);
                1, 5: set3(OP_RD, 8'($urandom), 8'h00, 2);
                2: begin
                    set3(OP_ALU, 8'($urandom), 8'($urandom), 3);
                    fq.push_back(8'($urandom_range(0, 5)));
                end
                3: set3(OP_NOP, 8'($urandom_range(0, 5)), 8'h00, 2);
                default: begin
                    do b = 8'($urandom);
                    while (b inside {OP_WR, OP_RD, OP_ALU, OP_NOP});
                    set3(b, 8'h00, 8'h00, 1);
                end
            endcase
            run_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
